// File: rtl/phy_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : phy_tx_arbiter
// Purpose  : Round-robin arbiter sharing the 32-bit PHY transmit datapath
//            between two word requesters, one word per WORD_CYCLES slot.
// Revision : 1.0 - initial release
// ============================================================================
module phy_tx_arbiter #(
    parameter int WORD_CYCLES = 32,
    parameter int MAX_BURST   = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic        valid_out,
    output logic [31:0] Data_out,
    output logic [1:0]  grant,
    output logic        slot_start
);

    localparam int                 c_CNT_W     = $clog2(WORD_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LAST_SLOT = c_CNT_W'(WORD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [3:0]         c_MAX_BURST = 4'(MAX_BURST);

    logic [c_CNT_W-1:0] r_slot_cnt;
    logic               r_valid_out;
    logic [31:0]        r_data_out;
    logic [1:0]         r_grant;
    logic               r_last_owner;
    logic               r_lock;
    logic [3:0]         r_burst_cnt;

    logic               w_dec;
    logic               w_sel;
    logic               w_sel_valid;
    logic               w_xfer;
    logic [31:0]        w_sel_data;
    logic               w_sel_last;
    logic [3:0]         w_burst_next;
    logic               w_release;

    // Under lock the last owner is the only candidate; a missing word idles the slot.
    always_comb begin
        w_sel       = 1'b0;
        w_sel_valid = 1'b0;
        if (r_lock) begin
            w_sel       = r_last_owner;
            w_sel_valid = r_last_owner ? req1_valid : req0_valid;
        end else if (req0_valid && req1_valid) begin
            w_sel       = ~r_last_owner;
            w_sel_valid = 1'b1;
        end else if (req0_valid) begin
            w_sel       = 1'b0;
            w_sel_valid = 1'b1;
        end else if (req1_valid) begin
            w_sel       = 1'b1;
            w_sel_valid = 1'b1;
        end
    end

    assign w_dec        = (r_slot_cnt == c_LAST_SLOT);
    assign w_xfer       = w_dec && w_sel_valid;
    assign w_sel_data   = w_sel ? req1_data : req0_data;
    assign w_sel_last   = w_sel ? req1_last : req0_last;
    assign w_burst_next = r_burst_cnt + 4'd1;
    assign w_release    = w_sel_last || (w_burst_next == c_MAX_BURST);

    assign req0_ready = reset && w_xfer && !w_sel;
    assign req1_ready = reset && w_xfer &&  w_sel;
    assign valid_out  = r_valid_out;
    assign Data_out   = r_data_out;
    assign grant      = r_grant;
    assign slot_start = (r_slot_cnt == '0);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_slot_cnt   <= '0;
            r_valid_out  <= 1'b0;
            r_data_out   <= 32'h0;
            r_grant      <= 2'b00;
            r_last_owner <= 1'b1;
            r_lock       <= 1'b0;
            r_burst_cnt  <= 4'd0;
        end else begin
            // Power-of-two slot length lets the counter wrap naturally.
            r_slot_cnt <= r_slot_cnt + c_CNT_ONE;
            if (w_dec) begin
                if (w_xfer) begin
                    r_valid_out  <= 1'b1;
                    r_data_out   <= w_sel_data;
                    r_grant      <= w_sel ? 2'b10 : 2'b01;
                    r_last_owner <= w_sel;
                    if (w_release) begin
                        r_lock      <= 1'b0;
                        r_burst_cnt <= 4'd0;
                    end else begin
                        r_lock      <= 1'b1;
                        r_burst_cnt <= w_burst_next;
                    end
                end else begin
                    r_valid_out <= 1'b0;
                    r_data_out  <= 32'h0;
                    r_grant     <= 2'b00;
                    r_lock      <= 1'b0;
                    r_burst_cnt <= 4'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_tx_arbiter
// Purpose  : Directed self-checking bench for phy_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_tx_arbiter;

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b0;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_data  = 32'h0;
    logic        req0_last  = 1'b0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_data  = 32'h0;
    logic        req1_last  = 1'b0;
    logic        req1_ready;
    logic        valid_out;
    logic [31:0] Data_out;
    logic [1:0]  grant;
    logic        slot_start;

    int checks   = 0;
    int failures = 0;

    // Bench-side slot position, restarted by reset.
    logic [4:0] tb_slot;

    phy_tx_arbiter #(.WORD_CYCLES(32), .MAX_BURST(4)) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .valid_out  (valid_out),
        .Data_out   (Data_out),
        .grant      (grant),
        .slot_start (slot_start)
    );

    always #5 clk_32f = ~clk_32f;

    always @(posedge clk_32f or negedge reset) begin
        if (!reset) tb_slot <= 5'd0;
        else        tb_slot <= tb_slot + 5'd1;
    end

    task automatic wait_slot(input int k);
        int n;
        n = 0;
        @(negedge clk_32f);
        while (int'(tb_slot) != k && n < 64) begin
            @(negedge clk_32f);
            n++;
        end
        if (int'(tb_slot) != k) begin
            checks++; failures++;
            $display("FAIL wait_slot timeout: slot=%0d required=%0d", tb_slot, k);
        end
    endtask

    task automatic set_req(input logic v0, input logic [31:0] d0, input logic l0,
                           input logic v1, input logic [31:0] d1, input logic l1);
        req0_valid = v0; req0_data = d0; req0_last = l0;
        req1_valid = v1; req1_data = d1; req1_last = l1;
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset = 1'b0;
        repeat (3) @(negedge clk_32f);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_req(1'b1, 32'hDEAD_0000, 1'b1, 1'b1, 32'hBEEF_0000, 1'b1);
        reset = 1'b0;
        repeat (3) @(negedge clk_32f);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b%b required 00", req0_ready, req1_ready);
        end
        checks++;
        if (valid_out !== 1'b0 || Data_out !== 32'h0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b data=%h grant=%b required 0/0/00",
                     valid_out, Data_out, grant);
        end
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            wait_slot(0);
            checks++;
            if (slot_start !== 1'b1 || valid_out !== 1'b0 || Data_out !== 32'h0 || grant !== 2'b00) begin
                failures++;
                $display("FAIL idle_slot%0d: start=%b valid=%b data=%h grant=%b required 1/0/0/00",
                         s, slot_start, valid_out, Data_out, grant);
            end
            wait_slot(5);
            checks++;
            if (slot_start !== 1'b0) begin
                failures++;
                $display("FAIL slot_start_mid%0d: got %b required 0", s, slot_start);
            end
        end
    endtask

    task automatic test_single();
        wait_slot(20);
        set_req(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0, 1'b0);
        wait_slot(30);
        checks++;
        if (req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_early_ready: got %b required 0", req0_ready);
        end
        wait_slot(31);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready: got %b%b required 10", req0_ready, req1_ready);
        end
        wait_slot(0);
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (valid_out !== 1'b1 || Data_out !== 32'hA5A5_0001 || grant !== 2'b01) begin
            failures++;
            $display("FAIL single_out: valid=%b data=%h grant=%b required 1/a5a50001/01",
                     valid_out, Data_out, grant);
        end
        wait_slot(31);
        checks++;
        if (valid_out !== 1'b1 || Data_out !== 32'hA5A5_0001 || req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_hold: valid=%b data=%h ready=%b required 1/a5a50001/0",
                     valid_out, Data_out, req0_ready);
        end
        wait_slot(0);
        checks++;
        if (valid_out !== 1'b0 || Data_out !== 32'h0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL single_idle: valid=%b data=%h grant=%b required 0/0/00",
                     valid_out, Data_out, grant);
        end
    endtask

    task automatic test_alternate();
        logic [3:0]  owners;
        logic [31:0] exp_data [4];
        int n0, n1;
        owners = 4'b1010;   // bit i = owner of slot i: 0,1,0,1
        exp_data[0] = 32'h1000_0001; exp_data[1] = 32'h2000_0001;
        exp_data[2] = 32'h1000_0002; exp_data[3] = 32'h2000_0002;
        n0 = 1; n1 = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_slot(31);
            set_req(1'b1, 32'h1000_0000 + 32'(n0), 1'b1, 1'b1, 32'h2000_0000 + 32'(n1), 1'b1);
            #1;
            checks++;
            if (req0_ready !== ~owners[i] || req1_ready !== owners[i]) begin
                failures++;
                $display("FAIL alt_ready%0d: got %b%b required %b%b", i,
                         req0_ready, req1_ready, ~owners[i], owners[i]);
            end
            wait_slot(0);
            if (owners[i]) n1++; else n0++;
            checks++;
            if (valid_out !== 1'b1 || grant !== (owners[i] ? 2'b10 : 2'b01) || Data_out !== exp_data[i]) begin
                failures++;
                $display("FAIL alt_out%0d: valid=%b grant=%b data=%h required 1/%b/%h", i,
                         valid_out, grant, Data_out, owners[i] ? 2'b10 : 2'b01, exp_data[i]);
            end
        end
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_slot(0);
    endtask

    task automatic test_burst();
        logic [6:0]  owners;
        logic [31:0] exp_data;
        int n1;
        owners = 7'b1101111;   // slots 0..3 req1, slot 4 req0, slots 5..6 req1
        n1 = 1;
        for (int i = 0; i < 7; i++) begin
            wait_slot(31);
            set_req(i != 0, 32'h3000_0000, 1'b1, 1'b1, 32'h4000_0000 + 32'(n1), 1'b0);
            #1;
            checks++;
            if (req0_ready !== ~owners[i] || req1_ready !== owners[i]) begin
                failures++;
                $display("FAIL burst_ready%0d: got %b%b required %b%b", i,
                         req0_ready, req1_ready, ~owners[i], owners[i]);
            end
            exp_data = owners[i] ? 32'h4000_0000 + 32'(n1) : 32'h3000_0000;
            wait_slot(0);
            if (owners[i]) n1++;
            checks++;
            if (grant !== (owners[i] ? 2'b10 : 2'b01) || Data_out !== exp_data) begin
                failures++;
                $display("FAIL burst_out%0d: grant=%b data=%h required %b/%h", i,
                         grant, Data_out, owners[i] ? 2'b10 : 2'b01, exp_data);
            end
        end
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_slot(0);
        checks++;
        if (valid_out !== 1'b0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL burst_end_idle: valid=%b grant=%b required 0/00", valid_out, grant);
        end
    endtask

    task automatic test_lock_drop();
        do_reset();
        wait_slot(31);
        set_req(1'b1, 32'h5000_0001, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_slot(31);
        set_req(1'b1, 32'h5000_0002, 1'b0, 1'b1, 32'h6000_0001, 1'b1);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL lock_hold_ready: got %b%b required 10", req0_ready, req1_ready);
        end
        wait_slot(31);
        set_req(1'b0, 32'h0, 1'b0, 1'b1, 32'h6000_0001, 1'b1);
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL lock_drop_ready: got %b%b required 00", req0_ready, req1_ready);
        end
        wait_slot(0);
        checks++;
        if (valid_out !== 1'b0 || grant !== 2'b00 || Data_out !== 32'h0) begin
            failures++;
            $display("FAIL lock_drop_idle: valid=%b grant=%b data=%h required 0/00/0",
                     valid_out, grant, Data_out);
        end
        wait_slot(31);
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL lock_next_ready: got %b%b required 01", req0_ready, req1_ready);
        end
        wait_slot(0);
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (valid_out !== 1'b1 || grant !== 2'b10 || Data_out !== 32'h6000_0001) begin
            failures++;
            $display("FAIL lock_next_out: valid=%b grant=%b data=%h required 1/10/60000001",
                     valid_out, grant, Data_out);
        end
    endtask

    task automatic test_reset_mid();
        int first;
        set_req(1'b1, 32'h7000_0001, 1'b1, 1'b0, 32'h0, 1'b0);
        wait_slot(10);
        reset = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || Data_out !== 32'h0 || grant !== 2'b00 || req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear: valid=%b data=%h grant=%b ready=%b required 0/0/00/0",
                     valid_out, Data_out, grant, req0_ready);
        end
        repeat (2) @(negedge clk_32f);
        reset = 1'b1;
        first = -1;
        for (int i = 1; i <= 40 && first < 0; i++) begin
            @(negedge clk_32f);
            #1;
            if (req0_ready === 1'b1) first = i;
        end
        checks++;
        if (first != 31) begin
            failures++;
            $display("FAIL midreset_first_ready: got cycle %0d required 31", first);
        end
        wait_slot(0);
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (grant !== 2'b01 || Data_out !== 32'h7000_0001) begin
            failures++;
            $display("FAIL midreset_grant: grant=%b data=%h required 01/70000001", grant, Data_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_burst();
        test_lock_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phy_tx_arbiter.md
Name: phy_tx_arbiter

Overview:
Round-robin arbiter that shares the single 32-bit transmit datapath of the PHY between two word requesters. It runs on clk_32f and enforces the PHY word slot: one 32-bit word accepted per WORD_CYCLES clocks. Each accepted word is held stable on Data_out/valid_out for a whole slot, and these outputs drive the PHY's Data_in/valid_in directly. Requesters may lock the datapath for a burst of words, ended by a last flag or by the MAX_BURST cap.

Parameters:
WORD_CYCLES, 32, clk_32f cycles per PHY word slot; power of two, at least 4.
MAX_BURST, 4, maximum consecutive slots one requester may hold under lock; range 1 to 15.

Ports:
clk_32f  input  1  PHY serial-rate clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
req0_valid  input  1  requester 0 has a word.
req0_data  input  32  requester 0 word.
req0_last  input  1  word is last of requester 0 burst.
req0_ready  output  1  requester 0 word is taken this cycle.
req1_valid  input  1  requester 1 has a word.
req1_data  input  32  requester 1 word.
req1_last  input  1  word is last of requester 1 burst.
req1_ready  output  1  requester 1 word is taken this cycle.
valid_out  output  1  to PHY valid_in; high for the whole slot carrying a word.
Data_out  output  32  to PHY Data_in; stable for the whole slot.
grant  output  2  one-hot owner of the current slot; 2'b00 when idle.
slot_start  output  1  one-cycle pulse when slot_cnt==0.

Behaviour:
- Reset (reset==0, async): slot_cnt=0, valid_out=0, Data_out=32'h0, grant=2'b00, last_owner=1 (so req0 wins first), lock=0, burst_cnt=0. req0_ready and req1_ready are 0 while reset is low.
- Slot counter: slot_cnt runs 0..WORD_CYCLES-1 and wraps. Decision cycle D is slot_cnt==WORD_CYCLES-1.
- Ready signals:
  - Combinational, asserted only in cycle D, for at most one requester.
  - Ready depends on valid; valid must not depend on ready.
  - A transfer is valid&&ready at the rising edge ending cycle D.
- Selection in cycle D:
  - If lock=1 and the owner is valid: the owner is selected.
  - If lock=1 and the owner is not valid: lock clears and the slot goes idle. The other requester is not served until the next D.
  - If lock=0 and only one requester is valid: that requester is selected.
  - If lock=0 and both are valid: the requester not equal to last_owner is selected.
  - If lock=0 and neither is valid: the slot is idle.
- On the edge ending D, when a transfer occurs:
  - Data_out<=selected data; valid_out<=1; grant<=selected one-hot; last_owner<=selected.
  - burst_cnt<=burst_cnt+1.
  - lock<=1 unless the transferred word has last==1 or burst_cnt+1==MAX_BURST. In either of those cases lock<=0 and burst_cnt<=0.
- On the edge ending D, when the slot is idle: valid_out<=0, Data_out<=0, grant<=0, burst_cnt<=0, lock<=0.
- Latency: a word taken at D appears on the next cycle (slot_cnt==0) and is held for exactly WORD_CYCLES cycles.
- Outputs change only on the edge ending D (or on reset). Requester inputs are ignored outside D.
- MAX_BURST==1: every word releases the lock; pure word-level round robin.
- Reset mid-slot clears everything immediately. After release, the first D occurs WORD_CYCLES-1 cycles later.

Test Plan:
- Reset then both valid idle for 3 slots -> valid_out=0, Data_out=0, grant=00; slot_start pulses every 32 cycles.
- req0 only, data 32'hA5A5_0001, last=1 -> req0_ready high in the single cycle slot_cnt==31; next 32 cycles valid_out=1, Data_out=32'hA5A5_0001, grant=01; then idle.
- Both valid continuously, last=1 every word, data 32'h1000_000n/32'h2000_000n -> slots alternate owner 0,1,0,1; req0 goes first after reset.
- req1 burst of 6 words, last never set, MAX_BURST=4, req0 valid throughout -> 4 req1 slots, then a req0 slot, then req1 again.
- Locked req0 drops valid at D mid-burst while req1 valid -> one idle slot (valid_out=0), then req1 granted at the following D.
- Assert reset at slot_cnt==10 during a granted slot -> valid_out, Data_out, grant go 0 asynchronously; after release the first ready occurs 31 cycles later.
